// File: rtl/jt12_pkg.sv
// Constants and helpers shared by the LFO, envelope generator and phase generator.
package jt12_pkg;

   localparam int LFO_MOD_W = 7;
   localparam int AM_W      = 7;

   // Samples per lfo_mod step, indexed by lfo_freq
   localparam logic [6:0] LFO_PERIOD [0:7] = '{
      7'd108, 7'd77, 7'd71, 7'd67, 7'd62, 7'd44, 7'd8, 7'd5
   };

   function automatic logic [6:0] lfo_period_m1(input logic [2:0] sel);
      return LFO_PERIOD[sel] - 7'd1;
   endfunction

   // Triangle folds the phase so am rises from 0 at mid-cycle to 126 at the ends
   function automatic logic [AM_W-1:0] lfo_am(input logic [LFO_MOD_W-1:0] mod);
      logic [5:0] tri_s;
      tri_s = mod[6] ? mod[5:0] : ~mod[5:0];
      return {tri_s, 1'b0};
   endfunction

endpackage

// File: rtl/jt12_lfo_div.sv
// Sample divider: counts tick strobes and pulses step when the programmed period elapses.
module jt12_lfo_div
   import jt12_pkg::*;
#(
   parameter int DIV_W = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             tick,
   input  logic [DIV_W-1:0] period_m1,
   output logic             step
);

   logic [DIV_W-1:0] div_cnt_r;
   logic             wrap_s;

   // Terminal detect uses >= so a shortened period wraps at once instead of overflowing
   always_comb begin
      wrap_s = 1'b0;
      if (div_cnt_r >= period_m1) begin
         wrap_s = 1'b1;
      end else begin
         wrap_s = 1'b0;
      end
      step = tick & ~clr & wrap_s;
   end

   // Divider counter, advanced only on tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (clr) begin
         div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick) begin
         if (wrap_s) begin
            div_cnt_r <= {DIV_W{1'b0}};
         end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
         end
      end else begin
         div_cnt_r <= div_cnt_r;
      end
   end

endmodule

// File: rtl/jt12_lfo.sv
// YM2612 LFO: phase counter for PM and triangular AM word for the EG.
// Define JT12_LFO_TEST_EN to add the test_lfo_step input (step on every zero strobe).
module jt12_lfo
   import jt12_pkg::*;
#(
   parameter int DIV_W = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 zero,
   input  logic                 lfo_en,
   input  logic [2:0]           lfo_freq,
`ifdef JT12_LFO_TEST_EN
   input  logic                 test_lfo_step,
`endif
   output logic [LFO_MOD_W-1:0] lfo_mod,
   output logic [AM_W-1:0]      am
);

   logic                 force_step_s;
   logic                 clr_s;
   logic                 div_step_s;
   logic                 adv_s;
   logic [LFO_MOD_W-1:0] next_mod_s;

`ifdef JT12_LFO_TEST_EN
   assign force_step_s = test_lfo_step & zero;
`else
   assign force_step_s = 1'b0;
`endif

   assign clr_s      = ~lfo_en | force_step_s;
   assign adv_s      = lfo_en & (force_step_s | div_step_s);
   assign next_mod_s = lfo_mod + 7'd1;

   jt12_lfo_div #(
      .DIV_W     (DIV_W)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr_s),
      .tick      (zero),
      .period_m1 (DIV_W'(lfo_period_m1(lfo_freq))),
      .step      (div_step_s)
   );

   // Phase and AM move together, am taken from the next phase value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfo_mod <= 7'd0;
         am      <= 7'd0;
      end else if (!lfo_en) begin
         lfo_mod <= 7'd0;
         am      <= 7'd0;
      end else if (adv_s) begin
         lfo_mod <= next_mod_s;
         am      <= lfo_am(next_mod_s);
      end else begin
         lfo_mod <= lfo_mod;
         am      <= am;
      end
   end

endmodule
